hazard_ctrl_unit: RTL and testbench

HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

---
 rtl/hazard_ctrl_unit.sv | 184 ++++++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use stall, branch flush, memory-wait freeze
// and halt drain, with sticky status flags and a stall-cycle counter.
module hazard_ctrl_unit #(
    parameter int DRAIN_CYCLES = 3,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  id_rs,
    input  logic [3:0]  id_rt,
    input  logic        id_rs_used,
    input  logic        id_rt_used,
    input  logic [3:0]  ex_rd,
    input  logic        ex_mem_to_reg,
    input  logic        br_taken,
    input  logic        halt_in,
    input  logic        mem_busy,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        idex_write,
    output logic        flush_ifid,
    output logic        idex_bubble,
    output logic        halted,
    output logic        mem_timeout,
    output logic [2:0]  ctrl_state,
    output logic [15:0] stall_cycles
);

    localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [DW-1:0] DRAIN_INIT  = DW'(DRAIN_CYCLES);
    localparam logic [7:0]    TIMEOUT_VAL = 8'(TIMEOUT);

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_LU_STALL = 3'd1,
        ST_MEM_WAIT = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_HALT     = 3'd4
    } state_t;

    state_t          state_reg, state_next;
    logic [DW-1:0]   drain_reg, drain_next;
    logic [7:0]      wait_reg, wait_next;
    logic [15:0]     stall_reg;
    logic            halted_reg;
    logic            timeout_reg;

    logic pc_en, ifid_en, idex_en, flush_en, bubble_en;

    // Per-source register match against the load destination in EX.
    logic [1:0][3:0] src_id;
    logic [1:0]      src_used;
    logic [1:0]      src_match;
    logic            load_use;

    assign src_id[0]   = id_rs;
    assign src_id[1]   = id_rt;
    assign src_used[0] = id_rs_used;
    assign src_used[1] = id_rt_used;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign src_match[gi] = src_used[gi] && (src_id[gi] == ex_rd);
        end
    endgenerate

    assign load_use = ex_mem_to_reg && (ex_rd != 4'd0) && (|src_match);

    always_comb begin
        state_next = state_reg;
        drain_next = drain_reg;
        wait_next  = wait_reg;
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        flush_en   = 1'b0;
        bubble_en  = 1'b0;

        case (state_reg)
            ST_RUN, ST_LU_STALL: begin
                if (mem_busy) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_en    = 1'b0;
                    wait_next  = 8'd0;
                    state_next = ST_MEM_WAIT;
                end else if (br_taken) begin
                    flush_en   = 1'b1;
                    bubble_en  = 1'b1;
                    state_next = ST_RUN;
                end else if (load_use && (state_reg == ST_RUN)) begin
                    // LU_STALL masks load_use so one load stalls one cycle only.
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    bubble_en  = 1'b1;
                    state_next = ST_LU_STALL;
                end else if (halt_in) begin
                    pc_en      = 1'b0;
                    flush_en   = 1'b1;
                    drain_next = DRAIN_INIT;
                    state_next = ST_DRAIN;
                end else begin
                    state_next = ST_RUN;
                end
            end

            ST_MEM_WAIT: begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_en    = 1'b0;
                wait_next  = (wait_reg == TIMEOUT_VAL) ? wait_reg : wait_reg + 8'd1;
                state_next = mem_busy ? ST_MEM_WAIT : ST_RUN;
            end

            ST_DRAIN: begin
                if (mem_busy) begin
                    pc_en   = 1'b0;
                    ifid_en = 1'b0;
                    idex_en = 1'b0;
                end else if (br_taken) begin
                    // An older taken branch means the HLT was on the wrong path.
                    flush_en   = 1'b1;
                    bubble_en  = 1'b1;
                    drain_next = '0;
                    state_next = ST_RUN;
                end else begin
                    pc_en      = 1'b0;
                    flush_en   = 1'b1;
                    drain_next = drain_reg - DW'(1);
                    if (drain_reg <= DW'(1)) begin
                        state_next = ST_HALT;
                    end
                end
            end

            ST_HALT: begin
                pc_en   = 1'b0;
                ifid_en = 1'b0;
                idex_en = 1'b0;
            end

            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_RUN;
            drain_reg   <= '0;
            wait_reg    <= 8'd0;
            stall_reg   <= 16'd0;
            halted_reg  <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            drain_reg <= drain_next;
            wait_reg  <= wait_next;
            if (!pc_en && (state_reg != ST_HALT) && (stall_reg != 16'hFFFF)) begin
                stall_reg <= stall_reg + 16'd1;
            end
            if (state_next == ST_HALT) begin
                halted_reg <= 1'b1;
            end
            if ((state_reg == ST_MEM_WAIT) && (wait_next == TIMEOUT_VAL)) begin
                timeout_reg <= 1'b1;
            end
        end
    end

    // Enables are forced low for the whole time reset is held.
    assign pc_write     = rst_n & pc_en;
    assign ifid_write   = rst_n & ifid_en;
    assign idex_write   = rst_n & idex_en;
    assign flush_ifid   = rst_n & flush_en;
    assign idex_bubble  = rst_n & bubble_en;
    assign halted       = halted_reg;
    assign mem_timeout  = timeout_reg;
    assign ctrl_state   = state_reg;
    assign stall_cycles = stall_reg;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Randomized and directed bench for hazard_ctrl_unit against a cycle-level
// behavioural model of the controller's rules.
module tb_hazard_ctrl_unit;

    localparam int P_DRAIN   = 3;
    localparam int P_TIMEOUT = 255;

    localparam int M_RUN  = 0;
    localparam int M_LU   = 1;
    localparam int M_MW   = 2;
    localparam int M_DR   = 3;
    localparam int M_HALT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  id_rs, id_rt, ex_rd;
    logic        id_rs_used, id_rt_used, ex_mem_to_reg;
    logic        br_taken, halt_in, mem_busy;
    logic        pc_write, ifid_write, idex_write, flush_ifid, idex_bubble;
    logic        halted, mem_timeout;
    logic [2:0]  ctrl_state;
    logic [15:0] stall_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    int m_mode, m_wait, m_drain, m_stall;
    bit m_halted, m_to;

    hazard_ctrl_unit #(.DRAIN_CYCLES(P_DRAIN), .TIMEOUT(P_TIMEOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rs_used   (id_rs_used),
        .id_rt_used   (id_rt_used),
        .ex_rd        (ex_rd),
        .ex_mem_to_reg(ex_mem_to_reg),
        .br_taken     (br_taken),
        .halt_in      (halt_in),
        .mem_busy     (mem_busy),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .idex_write   (idex_write),
        .flush_ifid   (flush_ifid),
        .idex_bubble  (idex_bubble),
        .halted       (halted),
        .mem_timeout  (mem_timeout),
        .ctrl_state   (ctrl_state),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_mode = M_RUN; m_wait = 0; m_drain = 0; m_stall = 0;
        m_halted = 0; m_to = 0;
    endfunction

    // Called at a negedge; leaves time at the next negedge, one posedge later.
    task automatic step(input logic [3:0] rs, input logic [3:0] rt, input logic rsu,
                        input logic rtu, input logic [3:0] rd, input logic m2r,
                        input logic br, input logic hlt, input logic mb);
        bit lu;
        bit e_pc, e_ifid, e_idex, e_fl, e_bub;
        int n_mode, n_wait, n_drain;
        id_rs = rs; id_rt = rt; id_rs_used = rsu; id_rt_used = rtu;
        ex_rd = rd; ex_mem_to_reg = m2r; br_taken = br; halt_in = hlt; mem_busy = mb;
        #1;
        lu = m2r && (rd != 0) && ((rsu && rs == rd) || (rtu && rt == rd));
        e_pc = 1; e_ifid = 1; e_idex = 1; e_fl = 0; e_bub = 0;
        n_mode = m_mode; n_wait = m_wait; n_drain = m_drain;
        if (m_mode == M_HALT) begin
            e_pc = 0; e_ifid = 0; e_idex = 0;
        end else if (m_mode == M_MW) begin
            e_pc = 0; e_ifid = 0; e_idex = 0;
            n_wait = (m_wait + 1 > P_TIMEOUT) ? P_TIMEOUT : m_wait + 1;
            n_mode = mb ? M_MW : M_RUN;
        end else if (m_mode == M_DR) begin
            if (mb) begin
                e_pc = 0; e_ifid = 0; e_idex = 0;
            end else if (br) begin
                e_fl = 1; e_bub = 1; n_mode = M_RUN; n_drain = 0;
            end else begin
                e_pc = 0; e_fl = 1; n_drain = m_drain - 1;
                if (n_drain == 0) n_mode = M_HALT;
            end
        end else begin
            n_mode = M_RUN;
            if (mb) begin
                e_pc = 0; e_ifid = 0; e_idex = 0; n_mode = M_MW; n_wait = 0;
            end else if (br) begin
                e_fl = 1; e_bub = 1;
            end else if (lu && m_mode == M_RUN) begin
                e_pc = 0; e_ifid = 0; e_bub = 1; n_mode = M_LU;
            end else if (hlt) begin
                e_pc = 0; e_fl = 1; n_mode = M_DR; n_drain = P_DRAIN;
            end
        end
        check_eq("pc_write", 32'(pc_write), 32'(e_pc));
        check_eq("ifid_write", 32'(ifid_write), 32'(e_ifid));
        check_eq("idex_write", 32'(idex_write), 32'(e_idex));
        check_eq("flush_ifid", 32'(flush_ifid), 32'(e_fl));
        check_eq("idex_bubble", 32'(idex_bubble), 32'(e_bub));
        check_eq("ctrl_state", 32'(ctrl_state), 32'(m_mode));
        check_eq("stall_cycles", 32'(stall_cycles), 32'(m_stall));
        check_eq("halted", 32'(halted), 32'(m_halted));
        check_eq("mem_timeout", 32'(mem_timeout), 32'(m_to));
        $display("step st=%0d in(br=%0d lu=%0d hlt=%0d mb=%0d) out(pc=%0d ifid=%0d idex=%0d fl=%0d bub=%0d) stall=%0d",
                 ctrl_state, br, lu, hlt, mb, pc_write, ifid_write, idex_write,
                 flush_ifid, idex_bubble, stall_cycles);
        if (!e_pc && m_mode != M_HALT && m_stall < 16'hFFFF) m_stall++;
        if (m_mode == M_MW && n_wait == P_TIMEOUT) m_to = 1;
        if (n_mode == M_HALT) m_halted = 1;
        m_mode = n_mode; m_wait = n_wait; m_drain = n_drain;
        @(negedge clk);
    endtask

    task automatic idle_step(input logic br, input logic hlt, input logic mb);
        step(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, br, hlt, mb);
    endtask

    task automatic rand_step();
        step(4'($urandom_range(3)), 4'($urandom_range(3)), 1'($urandom_range(1)),
             1'($urandom_range(1)), 4'($urandom_range(3)), 1'($urandom_range(99) < 45),
             1'($urandom_range(99) < 15), 1'($urandom_range(99) < 4),
             1'($urandom_range(99) < 15));
    endtask

    // Asserts reset away from any clock edge and checks the immediate effect.
    task automatic do_reset();
        rst_n = 1'b0;
        id_rs = 4'd5; id_rt = 4'd5; id_rs_used = 1'b1; id_rt_used = 1'b1;
        ex_rd = 4'd5; ex_mem_to_reg = 1'b1; br_taken = 1'($urandom_range(1));
        halt_in = 1'($urandom_range(1)); mem_busy = 1'($urandom_range(1));
        #1;
        check_eq("rst_pc_write", 32'(pc_write), 32'd0);
        check_eq("rst_ifid_write", 32'(ifid_write), 32'd0);
        check_eq("rst_idex_write", 32'(idex_write), 32'd0);
        check_eq("rst_flush_ifid", 32'(flush_ifid), 32'd0);
        check_eq("rst_idex_bubble", 32'(idex_bubble), 32'd0);
        check_eq("rst_ctrl_state", 32'(ctrl_state), 32'd0);
        check_eq("rst_stall_cycles", 32'(stall_cycles), 32'd0);
        check_eq("rst_halted", 32'(halted), 32'd0);
        check_eq("rst_mem_timeout", 32'(mem_timeout), 32'd0);
        $display("reset asserted: st=%0d halted=%0d stall=%0d", ctrl_state, halted, stall_cycles);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int halt_age;
        rst_n = 1'b0;
        id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
        ex_rd = 0; ex_mem_to_reg = 0; br_taken = 0; halt_in = 0; mem_busy = 0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Load-use on rs, then the same inputs in LU_STALL do not stall again.
        step(4'd5, 4'd0, 1'b1, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("lu_state", 32'(ctrl_state), 32'd1);
        check_eq("lu_release_pc", 32'(pc_write), 32'd1);
        check_eq("lu_stall_cnt", 32'(stall_cycles), 32'd1);
        step(4'd5, 4'd0, 1'b1, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("lu_back_run", 32'(ctrl_state), 32'd0);

        // R0 destination never stalls.
        step(4'd0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_eq("r0_state", 32'(ctrl_state), 32'd0);

        // Branch beats load-use and halt; memory busy beats everything.
        step(4'd5, 4'd5, 1'b1, 1'b1, 4'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        check_eq("br_prio_state", 32'(ctrl_state), 32'd0);
        step(4'd5, 4'd5, 1'b1, 1'b1, 4'd5, 1'b1, 1'b1, 1'b1, 1'b1);
        check_eq("mb_prio_state", 32'(ctrl_state), 32'd2);
        idle_step(1'b0, 1'b0, 1'b0);
        check_eq("mb_exit_state", 32'(ctrl_state), 32'd0);

        // Timeout boundary: RUN cycle plus 255 MEM_WAIT cycles.
        for (int k = 1; k <= 300; k++) begin
            idle_step(1'b0, 1'b0, 1'b1);
            if (k == 255) check_eq("to_before", 32'(mem_timeout), 32'd0);
            if (k == 256) check_eq("to_at", 32'(mem_timeout), 32'd1);
        end
        idle_step(1'b0, 1'b0, 1'b0);
        check_eq("to_exit_state", 32'(ctrl_state), 32'd0);
        check_eq("to_sticky", 32'(mem_timeout), 32'd1);
        do_reset();

        // Halt drain stretched by two busy cycles: five DRAIN cycles total.
        idle_step(1'b0, 1'b1, 1'b0);
        idle_step(1'b0, 1'b0, 1'b0);
        idle_step(1'b0, 1'b0, 1'b1);
        idle_step(1'b0, 1'b0, 1'b1);
        idle_step(1'b0, 1'b0, 1'b0);
        check_eq("drain_still", 32'(ctrl_state), 32'd3);
        idle_step(1'b0, 1'b0, 1'b0);
        check_eq("halt_state", 32'(ctrl_state), 32'd4);
        check_eq("halt_flag", 32'(halted), 32'd1);
        idle_step(1'b1, 1'b1, 1'b1);
        check_eq("halt_absorb", 32'(ctrl_state), 32'd4);
        do_reset();

        // Halt cancelled by a branch on the first DRAIN cycle.
        idle_step(1'b0, 1'b1, 1'b0);
        check_eq("cancel_in_drain", 32'(ctrl_state), 32'd3);
        idle_step(1'b1, 1'b0, 1'b0);
        check_eq("cancel_state", 32'(ctrl_state), 32'd0);
        check_eq("cancel_halted", 32'(halted), 32'd0);

        // Randomized traffic with occasional resets and recovery from HALT.
        halt_age = 0;
        for (int i = 0; i < 1200; i++) begin
            if (m_mode == M_HALT) halt_age++;
            else halt_age = 0;
            if (halt_age > 2 || $urandom_range(199) == 0) begin
                do_reset();
                halt_age = 0;
            end else begin
                rand_step();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
